// File: rtl/bsram_ctrl_pkg.sv
// Shared types and constants for the BSRAM port controller.
package bsram_ctrl_pkg;

    localparam int unsigned BYTE_LANES = 4;
    localparam logic [3:0]  BE_FULL    = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdData,
        StWr,
        StResp
    } state_t;

endpackage

// File: rtl/bsram_byte_merge.sv
// Byte-lane merge: take enabled lanes from wdata and the remaining lanes from rdata.
module bsram_byte_merge
    import bsram_ctrl_pkg::*;
(
    input  logic [BYTE_LANES-1:0]   be,
    input  logic [BYTE_LANES*8-1:0] wdata,
    input  logic [BYTE_LANES*8-1:0] rdata,
    output logic [BYTE_LANES*8-1:0] merged
);

    // Per-lane select between new store data and the word read back from memory.
    always_comb begin
        merged = rdata;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/bsram_port_ctrl.sv
// Load/store request controller for a single-port 1-cycle-latency BSRAM word memory.
// Partial stores are done as read-modify-write; memory controls are registered.
module bsram_port_ctrl
    import bsram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [3:0]          req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_ce,
    output logic                mem_oce,
    output logic                mem_reset,
    output logic                mem_wre,
    output logic [ADDR_W-1:0]   mem_ad,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout
);

    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   merged_word;

    // Byte offset within the word is irrelevant to a word memory.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    assign mem_oce   = 1'b1;
    assign mem_reset = reset;
    assign mem_ad    = addr_q;

    bsram_byte_merge u_merge (
        .be     (be_q),
        .wdata  (wdata_q),
        .rdata  (mem_dout),
        .merged (merged_word)
    );

    // Controller FSM; memory strobes are set on entry to the state that owns them,
    // so asynchronous reset drops them before an un-clocked write can happen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_ce    <= 1'b0;
            mem_wre   <= 1'b0;
            mem_din   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            mem_ce    <= 1'b0;
            mem_wre   <= 1'b0;
            mem_din   <= '0;
            unique case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        addr_q    <= req_addr[ADDR_W+1:2];
                        be_q      <= req_be;
                        wdata_q   <= req_wdata;
                        if (!req_we) begin
                            state_q <= StRdIssue;
                            mem_ce  <= 1'b1;
                        end else if (req_be == BE_FULL) begin
                            state_q <= StWr;
                            mem_ce  <= 1'b1;
                            mem_wre <= 1'b1;
                            mem_din <= req_wdata;
                        end else if (req_be == 4'h0) begin
                            // Nothing to write: complete without touching memory.
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                        end else begin
                            state_q <= StRdIssue;
                            mem_ce  <= 1'b1;
                        end
                    end
                end
                StRdIssue: begin
                    state_q <= StRdData;
                end
                StRdData: begin
                    if (!we_q) begin
                        rsp_rdata <= mem_dout;
                        rsp_valid <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        // mem_din doubles as the merge register for the RMW write.
                        mem_ce  <= 1'b1;
                        mem_wre <= 1'b1;
                        mem_din <= merged_word;
                        state_q <= StWr;
                    end
                end
                StWr: begin
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    req_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    req_ready <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsram_port_ctrl.sv
// Self-checking bench for bsram_port_ctrl with a behavioural BSRAM and a word-array model.
module tb_bsram_port_ctrl;

    localparam int ADDR_W = 11;
    localparam int WORDS  = 2048;

    logic                clk;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W+1:0]   req_addr;
    logic [3:0]          req_be;
    logic [31:0]         req_wdata;
    logic                rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                mem_ce;
    logic                mem_oce;
    logic                mem_reset;
    logic                mem_wre;
    logic [ADDR_W-1:0]   mem_ad;
    logic [31:0]         mem_din;
    logic [31:0]         mem_dout;

    int checks;
    int failures;

    // Behavioural single-port RAM, 1-cycle read latency
    logic [31:0] ram [WORDS];
    logic [31:0] seed_mem [WORDS];
    logic        preload;
    logic [31:0] ram_dout;

    // Reference model state
    logic [31:0] ref_mem [WORDS];
    logic [31:0] last_rdata;

    bsram_port_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_ce    (mem_ce),
        .mem_oce   (mem_oce),
        .mem_reset (mem_reset),
        .mem_wre   (mem_wre),
        .mem_ad    (mem_ad),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= seed_mem[i];
        end else if (mem_ce) begin
            if (mem_wre) ram[mem_ad] <= mem_din;
            else         ram_dout    <= ram[mem_ad];
        end
    end
    assign mem_dout = ram_dout;

    // Expected cycles from handshake edge to rsp_valid.
    function automatic int exp_lat(input logic we, input logic [3:0] be);
        if (!we)              return 3;
        else if (be == 4'hF)  return 2;
        else if (be == 4'h0)  return 1;
        else                  return 4;
    endfunction

    // Expected number of BSRAM accesses.
    function automatic int exp_acc(input logic we, input logic [3:0] be);
        if (!we)              return 1;
        else if (be == 4'hF)  return 1;
        else if (be == 4'h0)  return 0;
        else                  return 2;
    endfunction

    // Apply a transaction to the model; returns the rsp_rdata it should leave behind.
    task automatic model_txn(input logic we, input logic [12:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, output logic [31:0] exp_rdata);
        int w;
        logic [31:0] word;
        w = int'(addr) / 4;
        if (!we) begin
            last_rdata = ref_mem[w];
        end else begin
            word = ref_mem[w];
            for (int b = 0; b < 4; b++) begin
                if (be[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
            end
            ref_mem[w] = word;
        end
        exp_rdata = last_rdata;
    endtask

    // Issue one request and observe it to completion (no checking here).
    task automatic do_req(input logic we, input logic [12:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output int lat, output int acc,
                          output logic [10:0] ad_seen, output int early,
                          output logic [31:0] rdata_seen, output bit pulse_ok);
        int guard;
        lat = 0; acc = 0; early = 0; ad_seen = '0; rdata_seen = '0;
        @(negedge clk);
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (mem_ce === 1'b1) begin
                acc++;
                ad_seen = mem_ad;
            end
            if (req_ready === 1'b1) early++;
            if (rsp_valid === 1'b1) begin
                lat = i;
                rdata_seen = rsp_rdata;
                break;
            end
            // Junk on the request bus while busy must be ignored.
            req_valid = 1'($urandom); req_we = 1'($urandom);
            req_addr = 13'($urandom); req_be = 4'($urandom); req_wdata = $urandom;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        pulse_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
        checks++; if ({mem_ce, mem_wre} !== 2'b00) begin failures++; $display("FAIL rst_ce_wre got=%b exp=00", {mem_ce, mem_wre}); end
        checks++; if (mem_ad !== 11'h0 || mem_din !== 32'h0) begin failures++; $display("FAIL rst_ad_din got=%h/%h exp=0/0", mem_ad, mem_din); end
        checks++; if ({mem_oce, mem_reset} !== 2'b11) begin failures++; $display("FAIL rst_oce_mreset got=%b exp=11", {mem_oce, mem_reset}); end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        preload = 1'b0; reset = 1'b0;
        #1;
        checks++; if (mem_reset !== 1'b0) begin failures++; $display("FAIL rel_mem_reset got=%b exp=0", mem_reset); end
    endtask

    task automatic test_full_store_load();
        int lat, acc, early; logic [10:0] ad; logic [31:0] rd, exp; bit pok;
        do_req(1'b1, 13'h010, 4'hF, 32'hDEADBEEF, lat, acc, ad, early, rd, pok);
        model_txn(1'b1, 13'h010, 4'hF, 32'hDEADBEEF, exp);
        checks++; if (lat !== 2) begin failures++; $display("FAIL fstore_lat got=%0d exp=2", lat); end
        checks++; if (acc !== 1 || ad !== 11'h004) begin failures++; $display("FAIL fstore_access got=%0d@%h exp=1@004", acc, ad); end
        checks++; if (ram[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL fstore_mem got=%h exp=deadbeef", ram[4]); end
        checks++; if (rd !== exp) begin failures++; $display("FAIL fstore_rdata_kept got=%h exp=%h", rd, exp); end
        checks++; if (early !== 0 || !pok) begin failures++; $display("FAIL fstore_pulse ready_early=%0d pulse_ok=%0d exp=0/1", early, pok); end
        do_req(1'b0, 13'h010, 4'h0, 32'h0, lat, acc, ad, early, rd, pok);
        model_txn(1'b0, 13'h010, 4'h0, 32'h0, exp);
        checks++; if (lat !== 3) begin failures++; $display("FAIL load_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
        checks++; if (acc !== 1 || ad !== 11'h004) begin failures++; $display("FAIL load_access got=%0d@%h exp=1@004", acc, ad); end
    endtask

    task automatic test_reset_midop();
        int cnt; logic [31:0] old;
        // Abort a load in RD_DATA.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h040; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_hs got=%b%b exp=10", req_ready, rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL mid_rst_rdata got=%h exp=0", rsp_rdata); end
        checks++; if ({mem_ce, mem_wre} !== 2'b00 || mem_ad !== 11'h0 || mem_din !== 32'h0) begin
            failures++; $display("FAIL mid_rst_mem got=%b%b %h %h exp=00 000 0", mem_ce, mem_wre, mem_ad, mem_din); end
        last_rdata = 32'h0;
        @(negedge clk); reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL mid_rst_no_rsp got=%0d exp=0", cnt); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready); end
        // Abort a full store while in WR, before the BSRAM clocks it.
        old = ref_mem[16];
        req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h040; req_be = 4'hF; req_wdata = ~old;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        checks++; if (ram[16] !== old) begin failures++; $display("FAIL wr_abort_mem got=%h exp=%h", ram[16], old); end
    endtask

    task automatic test_rmw();
        int lat, acc, early; logic [10:0] ad; logic [31:0] rd, exp; bit pok;
        do_req(1'b1, 13'h010, 4'hF, 32'h11223344, lat, acc, ad, early, rd, pok);
        model_txn(1'b1, 13'h010, 4'hF, 32'h11223344, exp);
        do_req(1'b1, 13'h010, 4'b0101, 32'hAABBCCDD, lat, acc, ad, early, rd, pok);
        model_txn(1'b1, 13'h010, 4'b0101, 32'hAABBCCDD, exp);
        checks++; if (lat !== 4) begin failures++; $display("FAIL rmw_lat got=%0d exp=4", lat); end
        checks++; if (acc !== 2 || ad !== 11'h004) begin failures++; $display("FAIL rmw_access got=%0d@%h exp=2@004", acc, ad); end
        checks++; if (ram[4] !== 32'h11BB33DD) begin failures++; $display("FAIL rmw_mem got=%h exp=11bb33dd", ram[4]); end
        checks++; if (rd !== exp) begin failures++; $display("FAIL rmw_rdata_kept got=%h exp=%h", rd, exp); end
    endtask

    task automatic test_be_zero();
        int lat, acc, early; logic [10:0] ad; logic [31:0] rd, exp, old; bit pok;
        old = ref_mem[8];
        do_req(1'b1, 13'h020, 4'h0, ~old, lat, acc, ad, early, rd, pok);
        model_txn(1'b1, 13'h020, 4'h0, ~old, exp);
        checks++; if (lat !== 1) begin failures++; $display("FAIL be0_lat got=%0d exp=1", lat); end
        checks++; if (acc !== 0) begin failures++; $display("FAIL be0_access got=%0d exp=0", acc); end
        checks++; if (ram[8] !== old) begin failures++; $display("FAIL be0_mem got=%h exp=%h", ram[8], old); end
        checks++; if (!pok) begin failures++; $display("FAIL be0_pulse got=0 exp=1"); end
    endtask

    task automatic test_back_to_back();
        int idx, ready_cnt;
        int rsp_t[$];
        int hs_t[$];
        logic [31:0] rsp_d[$];
        bit pend;
        idx = 0; ready_cnt = 0; pend = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_be = 4'($urandom); req_addr = 13'h0; req_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (pend) begin
                pend = 1'b0;
                idx++;
                if (idx < 3) req_addr = 13'(idx * 4);
                else req_valid = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                rsp_t.push_back(t);
                rsp_d.push_back(rsp_rdata);
            end
            if (req_ready === 1'b1) ready_cnt++;
            if (req_ready === 1'b1 && req_valid === 1'b1) begin
                hs_t.push_back(t);
                pend = 1'b1;
            end
            if (rsp_t.size() >= 3) break;
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++; if (rsp_t.size() !== 3 || hs_t.size() !== 3) begin
            failures++; $display("FAIL b2b_counts got=%0d rsp/%0d hs exp=3/3", rsp_t.size(), hs_t.size()); end
        checks++; if (ready_cnt !== 3) begin failures++; $display("FAIL b2b_ready_cycles got=%0d exp=3", ready_cnt); end
        for (int i = 0; i < 3; i++) begin
            if (i < rsp_t.size() && i < hs_t.size()) begin
                checks++; if (rsp_t[i] - hs_t[i] !== 3) begin
                    failures++; $display("FAIL b2b_lat[%0d] got=%0d exp=3", i, rsp_t[i] - hs_t[i]); end
                checks++; if (rsp_d[i] !== ref_mem[i]) begin
                    failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rsp_d[i], ref_mem[i]); end
                if (i > 0) begin
                    checks++; if (rsp_t[i] - rsp_t[i-1] !== 4) begin
                        failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=4", i, rsp_t[i] - rsp_t[i-1]); end
                end
            end
        end
        last_rdata = ref_mem[2];
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int lat, acc, early; logic [10:0] ad; logic [31:0] rd, exp; bit pok;
        do_req(1'b0, 13'h1FFC, 4'h0, 32'h0, lat, acc, ad, early, rd, pok);
        model_txn(1'b0, 13'h1FFC, 4'h0, 32'h0, exp);
        checks++; if (ad !== 11'h7FF) begin failures++; $display("FAIL wrap_ad got=%h exp=7ff", ad); end
        checks++; if (rd !== exp) begin failures++; $display("FAIL wrap_rdata got=%h exp=%h", rd, exp); end
        do_req(1'b1, 13'h1FFF, 4'hF, 32'hCAFEF00D, lat, acc, ad, early, rd, pok);
        model_txn(1'b1, 13'h1FFF, 4'hF, 32'hCAFEF00D, exp);
        do_req(1'b0, 13'h1FFD, 4'h0, 32'h0, lat, acc, ad, early, rd, pok);
        model_txn(1'b0, 13'h1FFD, 4'h0, 32'h0, exp);
        checks++; if (ad !== 11'h7FF || rd !== 32'hCAFEF00D) begin
            failures++; $display("FAIL wrap_lowbits got=%h@%h exp=cafef00d@7ff", rd, ad); end
    endtask

    task automatic test_random();
        int lat, acc, early; logic [10:0] ad; logic [31:0] rd, exp, wd; bit pok;
        logic we; logic [12:0] addr; logic [3:0] be;
        int bad;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom);
            case ($urandom_range(0, 3))
                0: be = 4'hF;
                1: be = 4'h0;
                default: be = 4'($urandom);
            endcase
            addr = (n % 2 == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom);
            wd = $urandom;
            do_req(we, addr, be, wd, lat, acc, ad, early, rd, pok);
            model_txn(we, addr, be, wd, exp);
            checks++; if (lat !== exp_lat(we, be)) begin
                failures++; $display("FAIL rnd_lat[%0d] we=%b be=%h got=%0d exp=%0d", n, we, be, lat, exp_lat(we, be)); end
            checks++; if (acc !== exp_acc(we, be)) begin
                failures++; $display("FAIL rnd_acc[%0d] got=%0d exp=%0d", n, acc, exp_acc(we, be)); end
            checks++; if (rd !== exp) begin
                failures++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, rd, exp); end
            checks++; if (early !== 0 || !pok) begin
                failures++; $display("FAIL rnd_handshake[%0d] ready_early=%0d pulse_ok=%0d exp=0/1", n, early, pok); end
        end
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL final_mem got=%0d bad words exp=0", bad); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last_rdata = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            seed_mem[i] = $urandom;
            ref_mem[i]  = seed_mem[i];
        end
        test_reset();
        test_full_store_load();
        test_reset_midop();
        test_rmw();
        test_be_zero();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
